// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM states, redirect encoding,
// reset constants and the branch-target helper.
package mips_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } fetch_state_e;

  typedef enum logic [1:0] {
    RedirNone,
    RedirBr,
    RedirJmp,
    RedirJr
  } redir_sel_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Branch offset is a signed word count relative to the delay-slot-free PC+4.
  function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] offset);
    return pc4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Redirect resolution for the fetch stage: priority select (jr > jmp > branch), target
// computation and misaligned-jr detection. Purely combinational.
module if_npc_sel
  import mips_pkg::*;
(
  input  logic        redirect_en_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_offset_i,
  input  logic        jmp_i,
  input  logic [25:0] jmp_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic [31:0] if_id_pc4_i,
  output redir_sel_e  sel_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  always_comb begin
    sel_o = RedirNone;
    if (redirect_en_i) begin
      if (jr_i) begin
        sel_o = RedirJr;
      end else if (jmp_i) begin
        sel_o = RedirJmp;
      end else if (br_taken_i) begin
        sel_o = RedirBr;
      end
    end
  end

  always_comb begin
    target_o = '0;
    unique case (sel_o)
      RedirJr:  target_o = jr_target_i;
      RedirJmp: target_o = {if_id_pc4_i[31:28], jmp_index_i, 2'b00};
      RedirBr:  target_o = br_target(if_id_pc4_i, br_offset_i);
      default:  target_o = '0;
    endcase
  end

  assign misaligned_o = (sel_o == RedirJr) && (jr_target_i[1:0] != 2'b00);

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, synchronous-read imem interface, IF/ID register,
// and a BOOT/RUN/HALT control FSM with ID-stage redirects and hazard stalls.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [15:0]       br_offset_i,
  input  logic              jmp_i,
  input  logic [25:0]       jmp_index_i,
  input  logic              jr_i,
  input  logic [31:0]       jr_target_i,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       pc_f_o,
  output logic [31:0]       if_id_instr_o,
  output logic [31:0]       if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic              addr_err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [31:0]  npc;
  logic         imem_en;
  logic         redirect_en;
  redir_sel_e   redir_sel;
  logic [31:0]  redir_target;
  logic         redir_misaligned;

  // Redirects only count when ID holds a real instruction and is not being held by a hazard.
  assign redirect_en = (state_q == StRun) && valid_q && !stall_i;

  if_npc_sel u_npc_sel (
    .redirect_en_i (redirect_en),
    .br_taken_i    (br_taken_i),
    .br_offset_i   (br_offset_i),
    .jmp_i         (jmp_i),
    .jmp_index_i   (jmp_index_i),
    .jr_i          (jr_i),
    .jr_target_i   (jr_target_i),
    .if_id_pc4_i   (pc4_q),
    .sel_o         (redir_sel),
    .target_o      (redir_target),
    .misaligned_o  (redir_misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    npc     = pc_q;
    imem_en = 1'b0;

    unique case (state_q)
      StBoot: begin
        imem_en = 1'b1;
        npc     = pc_q;
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        imem_en = 1'b1;
        if (stall_i) begin
          // Re-read the same word so imem data stays aligned with pc_q after the stall.
          npc = pc_q;
        end else if (redir_sel != RedirNone) begin
          npc     = redir_target;
          instr_d = NOP_INSTR;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (redir_misaligned) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end else begin
          npc     = pc_q + 32'd4;
          instr_d = imem_rdata_i;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
        end
        pc_d = npc;
      end
      StHalt: begin
        imem_en = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    if (rst_i) begin
      imem_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_en_o     = imem_en;
  assign imem_addr_o   = npc[ADDR_W+1:2];
  assign pc_f_o        = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign addr_err_o    = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then random ID/hazard
// traffic checked every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0000_3000;
  localparam int unsigned Aw    = 10;

  logic          clk = 1'b0;
  logic          rst, stall, br_taken, jmp, jr;
  logic [15:0]   br_offset;
  logic [25:0]   jmp_index;
  logic [31:0]   jr_target;
  logic          imem_en;
  logic [Aw-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc_f, if_id_instr, if_id_pc4;
  logic          if_id_valid, addr_err;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (RstPc),
    .ADDR_W   (Aw)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_offset_i   (br_offset),
    .jmp_i         (jmp),
    .jmp_index_i   (jmp_index),
    .jr_i          (jr),
    .jr_target_i   (jr_target),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .pc_f_o        (pc_f),
    .if_id_instr_o (if_id_instr),
    .if_id_pc4_o   (if_id_pc4),
    .if_id_valid_o (if_id_valid),
    .addr_err_o    (addr_err)
  );

  // Synchronous-read instruction memory.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;  // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;

  function automatic logic [Aw-1:0] widx(input logic [31:0] a);
    return Aw'((a / 4) % 1024);
  endfunction

  function automatic bit m_redirect();
    return (m_state == 1) && m_valid && !stall && (jr || jmp || br_taken);
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] off;
    if (jr) return jr_target;
    if (jmp) return (m_pc4 & 32'hF000_0000) | (32'(jmp_index) * 4);
    off = br_offset[15] ? (32'(br_offset) - 32'h0001_0000) : 32'(br_offset);
    return m_pc4 + off * 4;
  endfunction

  function automatic logic [31:0] m_npc();
    if (m_state == 0 || stall) return m_pc;
    if (m_redirect()) return m_target();
    return m_pc + 4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pc = RstPc; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (m_state == 1 && !stall) begin
      if (m_redirect()) begin
        logic [31:0] t;
        t = m_target();
        if (jr && t[1:0] != 2'b00) begin
          m_err = 1; m_state = 2;
        end
        m_pc = t; m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
        m_instr = mem[widx(m_pc)]; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic exp_en;
      exp_en = !rst && (m_state != 2);
      chk("cyc_imem_en", 32'(imem_en), 32'(exp_en));
      if (exp_en) chk("cyc_imem_addr", 32'(imem_addr), 32'(widx(m_npc())));
      chk("cyc_pc_f", pc_f, m_pc);
      chk("cyc_instr", if_id_instr, m_instr);
      chk("cyc_pc4", if_id_pc4, m_pc4);
      chk("cyc_valid", 32'(if_id_valid), 32'(m_valid));
      chk("cyc_addr_err", 32'(addr_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] saved_instr;
    int          halt_cnt;
    logic [31:0] r;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[widx(32'h3000)] = 32'h2408_0005;

    rst = 1; stall = 0; br_taken = 0; br_offset = 0; jmp = 0; jmp_index = 0;
    jr = 0; jr_target = 0;

    // Reset and boot
    tick();
    cmp_on = 1'b1;
    tick();
    chk("rst_imem_en", 32'(imem_en), 32'h0);
    chk("rst_pc_f", pc_f, 32'h3000);
    rst = 0;
    tick();
    chk("boot_valid", 32'(if_id_valid), 32'h0);
    tick();
    chk("first_instr", if_id_instr, 32'h2408_0005);
    chk("first_pc4", if_id_pc4, 32'h3004);
    chk("first_pc_f", pc_f, 32'h3004);

    // Backward branch
    tick();
    chk("br_pre_pc4", if_id_pc4, 32'h3008);
    br_taken = 1; br_offset = 16'hFFFE;
    #1;
    chk("br_imem_addr", 32'(imem_addr), 32'h0);
    tick();
    br_taken = 0;
    chk("br_bubble", 32'(if_id_valid), 32'h0);
    chk("br_pc_f", pc_f, 32'h3000);
    tick();
    chk("br_tgt_pc4", if_id_pc4, 32'h3004);
    chk("br_tgt_valid", 32'(if_id_valid), 32'h1);

    // Jump
    repeat (3) tick();
    chk("j_pre_pc4", if_id_pc4, 32'h3010);
    jmp = 1; jmp_index = 26'h000_0C10;
    tick();
    jmp = 0;
    chk("j_pc_f", pc_f, 32'h3040);
    chk("j_bubble", 32'(if_id_valid), 32'h0);
    tick();
    chk("j_tgt_pc4", if_id_pc4, 32'h3044);

    // Stall held against a taken branch
    saved_instr = if_id_instr;
    stall = 1; br_taken = 1; br_offset = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_imem_addr", 32'(imem_addr), 32'h011);
      tick();
      chk("stall_instr", if_id_instr, saved_instr);
      chk("stall_pc4", if_id_pc4, 32'h3044);
      chk("stall_pc_f", pc_f, 32'h3044);
    end
    stall = 0;
    #1;
    chk("unstall_imem_addr", 32'(imem_addr), 32'h015);
    tick();
    br_taken = 0;
    chk("unstall_pc_f", pc_f, 32'h3054);
    chk("unstall_bubble", 32'(if_id_valid), 32'h0);

    // Misaligned jr halts until reset
    tick();
    jr = 1; jr_target = 32'h3002;
    tick();
    jr = 0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_err", 32'(addr_err), 32'h1);
      chk("halt_imem_en", 32'(imem_en), 32'h0);
      chk("halt_valid", 32'(if_id_valid), 32'h0);
      chk("halt_pc_f", pc_f, 32'h3002);
      tick();
    end
    rst = 1;
    tick();
    chk("halt_rst_err", 32'(addr_err), 32'h0);
    chk("halt_rst_pc_f", pc_f, 32'h3000);
    rst = 0;
    #1;
    chk("reboot_imem_en", 32'(imem_en), 32'h1);
    chk("reboot_imem_addr", 32'(imem_addr), 32'h0);
    tick();
    tick();
    chk("reboot_instr", if_id_instr, 32'h2408_0005);

    // Address wrap, and a redirect while IF/ID is a bubble
    jr = 1; jr_target = 32'hFFFF_FFFC;
    tick();
    jr = 0; br_taken = 1; br_offset = 16'h0010;
    chk("wrap_pc_f", pc_f, 32'hFFFF_FFFC);
    #1;
    chk("wrap_imem_addr", 32'(imem_addr), 32'h0);
    tick();
    br_taken = 0;
    chk("wrap_next_pc_f", pc_f, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, mem[1023]);

    // Random traffic
    halt_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      halt_cnt = (m_state == 2) ? halt_cnt + 1 : 0;
      rst       = (halt_cnt > 6) || ($urandom_range(0, 299) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      br_offset = 16'($urandom);
      jmp       = ($urandom_range(0, 11) == 0);
      jmp_index = 26'($urandom);
      jr        = ($urandom_range(0, 11) == 0);
      r         = $urandom;
      jr_target = ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00};
      tick();
    end
    rst = 0; stall = 0; br_taken = 0; jmp = 0; jr = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
